// File: rtl/hc_tx_port_arbiter_pkg.sv
// Shared definitions for the host-controller SIE transmit-port arbiter:
// FSM state encodings, requester indices and the winner-selection helper.
package hc_tx_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_SOF  = 3'd1,
    GNT_PKT  = 3'd2,
    GNT_DRCT = 3'd3,
    RELEASE  = 3'd4
  } arbState_e;

  localparam logic [1:0] REQ_SOF  = 2'd0;
  localparam logic [1:0] REQ_PKT  = 2'd1;
  localparam logic [1:0] REQ_DRCT = 2'd2;

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      REQ_SOF: nxt = REQ_PKT;
      REQ_PKT: nxt = REQ_DRCT;
      default: nxt = REQ_SOF;
    endcase
    return nxt;
  endfunction

  // First requesting index found when walking the ring from startIdx.
  function automatic logic [1:0] pickWinner(input logic [2:0] req, input logic [1:0] startIdx);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] win;
    c0 = startIdx;
    c1 = nextIdx(c0);
    c2 = nextIdx(c1);
    if (req[c0]) begin
      win = c0;
    end else if (req[c1]) begin
      win = c1;
    end else if (req[c2]) begin
      win = c2;
    end else begin
      win = startIdx;
    end
    return win;
  endfunction

endpackage

// File: rtl/hc_tx_port_mux.sv
// One-hot grant driven 3:1 select of write strobe, data and control bytes;
// everything reads as zero when no requester holds the grant.
module hc_tx_port_mux
  import hc_tx_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        gntVec,
  input  logic [2:0]        wenVec,
  input  logic [DATA_W-1:0] sofData,
  input  logic [DATA_W-1:0] sofCntl,
  input  logic [DATA_W-1:0] pktData,
  input  logic [DATA_W-1:0] pktCntl,
  input  logic [DATA_W-1:0] drctData,
  input  logic [DATA_W-1:0] drctCntl,
  output logic              txWEn,
  output logic [DATA_W-1:0] txData,
  output logic [DATA_W-1:0] txCntl
);

  // Route the granted requester onto the SIE port, zero otherwise.
  always_comb begin
    txWEn  = 1'b0;
    txData = {DATA_W{1'b0}};
    txCntl = {DATA_W{1'b0}};
    case (gntVec)
      3'b001: begin
        txWEn  = wenVec[REQ_SOF];
        txData = sofData;
        txCntl = sofCntl;
      end
      3'b010: begin
        txWEn  = wenVec[REQ_PKT];
        txData = pktData;
        txCntl = pktCntl;
      end
      3'b100: begin
        txWEn  = wenVec[REQ_DRCT];
        txData = drctData;
        txCntl = drctCntl;
      end
      default: begin
        txWEn  = 1'b0;
        txData = {DATA_W{1'b0}};
        txCntl = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/hc_tx_port_arbiter.sv
// Arbitrates the single SIE transmit port between SOF, packet and direct
// line-state requesters; non-preemptive, one dead RELEASE cycle per handover.
module hc_tx_port_arbiter
  import hc_tx_port_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sofTxReq,
  output logic              sofTxGnt,
  input  logic              sofTxWEn,
  input  logic [DATA_W-1:0] sofTxData,
  input  logic [DATA_W-1:0] sofTxCntl,
  input  logic              pktTxReq,
  output logic              pktTxGnt,
  input  logic              pktTxWEn,
  input  logic [DATA_W-1:0] pktTxData,
  input  logic [DATA_W-1:0] pktTxCntl,
  input  logic              drctTxReq,
  output logic              drctTxGnt,
  input  logic              drctTxWEn,
  input  logic [DATA_W-1:0] drctTxData,
  input  logic [DATA_W-1:0] drctTxCntl,
  output logic              SIETxWEn,
  output logic [DATA_W-1:0] SIETxData,
  output logic [DATA_W-1:0] SIETxCntl,
  output logic              arbProtErr
);

  arbState_e  state_r;
  arbState_e  stateNext_s;
  logic [2:0] gntVec_r;
  logic [2:0] gntNext_s;
  logic [1:0] rrPtr_r;
  logic [1:0] ptrNext_s;
  logic [1:0] startIdx_s;
  logic [1:0] winner_s;
  logic [2:0] reqVec_s;
  logic [2:0] wenVec_s;
  logic       protErr_r;

  assign reqVec_s   = {drctTxReq, pktTxReq, sofTxReq};
  assign wenVec_s   = {drctTxWEn, pktTxWEn, sofTxWEn};
  // rrPtr_r holds the first index to consider, i.e. one past the last winner.
  assign startIdx_s = (ROUND_ROBIN != 0) ? rrPtr_r : REQ_SOF;
  assign winner_s   = pickWinner(reqVec_s, startIdx_s);

  // Next-state, next-grant and pointer-update decisions.
  always_comb begin
    stateNext_s = state_r;
    gntNext_s   = 3'b000;
    ptrNext_s   = rrPtr_r;
    case (state_r)
      IDLE: begin
        if (|reqVec_s) begin
          gntNext_s = 3'b001 << winner_s;
          ptrNext_s = nextIdx(winner_s);
          case (winner_s)
            REQ_SOF:  stateNext_s = GNT_SOF;
            REQ_PKT:  stateNext_s = GNT_PKT;
            default:  stateNext_s = GNT_DRCT;
          endcase
        end else begin
          stateNext_s = IDLE;
        end
      end
      GNT_SOF: begin
        if (reqVec_s[REQ_SOF]) begin
          gntNext_s = 3'b001;
        end else begin
          stateNext_s = RELEASE;
        end
      end
      GNT_PKT: begin
        if (reqVec_s[REQ_PKT]) begin
          gntNext_s = 3'b010;
        end else begin
          stateNext_s = RELEASE;
        end
      end
      GNT_DRCT: begin
        if (reqVec_s[REQ_DRCT]) begin
          gntNext_s = 3'b100;
        end else begin
          stateNext_s = RELEASE;
        end
      end
      RELEASE: stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State, grant, pointer and protocol-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gntVec_r  <= 3'b000;
      rrPtr_r   <= REQ_SOF;
      protErr_r <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      gntVec_r  <= gntNext_s;
      rrPtr_r   <= ptrNext_s;
      protErr_r <= |(wenVec_s & ~gntVec_r);
    end
  end

  assign sofTxGnt   = gntVec_r[REQ_SOF];
  assign pktTxGnt   = gntVec_r[REQ_PKT];
  assign drctTxGnt  = gntVec_r[REQ_DRCT];
  assign arbProtErr = protErr_r;

  hc_tx_port_mux #(.DATA_W(DATA_W)) uMux (
    .gntVec   (gntVec_r),
    .wenVec   (wenVec_s),
    .sofData  (sofTxData),
    .sofCntl  (sofTxCntl),
    .pktData  (pktTxData),
    .pktCntl  (pktTxCntl),
    .drctData (drctTxData),
    .drctCntl (drctTxCntl),
    .txWEn    (SIETxWEn),
    .txData   (SIETxData),
    .txCntl   (SIETxCntl)
  );

endmodule

// File: doc/hc_tx_port_arbiter.md
Name: hc_tx_port_arbiter

Overview:
Shares the single host-controller SIE transmit port between three requesters: SOF transmitter (SOF), packet sender (PKT) and direct line-state control (DRCT). Each requester runs the Req/Gnt/Rdy/WEn handshake and drives its own Data/Cntl bytes. The arbiter grants one requester at a time and muxes that requester's write strobe, data and control onto the SIE TX port. It sits between the host-controller FSMs and the SIE transmitter.

Parameters:
ROUND_ROBIN, 0, 0 = fixed priority SOF > PKT > DRCT; 1 = rotating priority starting after the last granted requester
DATA_W, 8, width of TX data and TX control bytes

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
sofTxReq  in  1  SOF requester holds high for the whole transaction
sofTxGnt  out  1  grant to SOF
sofTxWEn  in  1  SOF write strobe
sofTxData  in  DATA_W  SOF data byte
sofTxCntl  in  DATA_W  SOF control byte
pktTxReq / pktTxGnt / pktTxWEn / pktTxData / pktTxCntl  same as SOF set, packet sender
drctTxReq / drctTxGnt / drctTxWEn / drctTxData / drctTxCntl  same as SOF set, direct control
SIETxWEn  out  1  muxed write strobe to SIE
SIETxData  out  DATA_W  muxed data byte
SIETxCntl  out  DATA_W  muxed control byte
arbProtErr  out  1  one-cycle pulse: WEn asserted by a non-granted requester

Behaviour:
- Reset: state IDLE, all Gnt = 0, SIETxWEn = 0, SIETxData = 0, SIETxCntl = 0, arbProtErr = 0, round-robin pointer = SOF. Reset mid-grant drops the grant on the next edge and ignores any in-flight WEn.
- FSM states: IDLE, GNT_SOF, GNT_PKT, GNT_DRCT, RELEASE.
- IDLE: if any Req is high, select the winner, go to GNT_x and register its Gnt = 1. Req-to-Gnt latency is exactly 1 clock.
- GNT_x: Gnt_x held high while Req_x = 1. SIETxWEn/Data/Cntl = requester x inputs, combinational, same cycle. When Req_x = 0, Gnt_x drops on the next edge and the FSM enters RELEASE.
- RELEASE: exactly one dead cycle with no grant, then IDLE. Back-to-back transactions therefore see at least 2 clocks between Gnt edges.
- Gnt outputs are one-hot or zero and registered. Rdy does not pass through the arbiter; it is broadcast from the SIE to all requesters.
- Fixed priority (ROUND_ROBIN = 0) on simultaneous requests: SOF > PKT > DRCT.
- Round-robin (ROUND_ROBIN = 1): search order starts at the requester after the last granted one. The pointer updates on entry to GNT_x.
- No preemption. A higher-priority Req arriving during a grant waits for release.
- Not granted, or in IDLE/RELEASE: SIETxWEn = 0, Data = 0, Cntl = 0.
- WEn = 1 from any requester not currently granted: arbProtErr pulses 1 cycle later and the strobe is dropped.
- Req dropping and re-asserting in the same cycle it is sampled: treated as release. The requester re-arbitrates after RELEASE.

Decomposition:
- Shared package: state encodings (IDLE, GNT_SOF, GNT_PKT, GNT_DRCT, RELEASE) and requester index constants (REQ_SOF = 0, REQ_PKT = 1, REQ_DRCT = 2).
- TX_* control codes stay in the existing SIE header.
- One sub-module, hc_tx_port_mux: combinational 3:1 select of WEn/Data/Cntl plus zeroing, driven by the one-hot grant vector.

Test Plan:
- Reset then idle, no Req: all Gnt = 0, SIETxWEn = 0, Data = 8'h00, Cntl = 8'h00 for 20 cycles.
- Single grant: drctTxReq = 1 at cycle 0 → drctTxGnt = 1 at cycle 1. drctTxWEn with Data 8'h02 → SIETxData = 8'h02 in the same cycle. Req low → Gnt low on the next edge.
- Simultaneous requests, ROUND_ROBIN = 0: all three Req = 1 → grant order SOF, PKT, DRCT, each grant separated by one RELEASE cycle.
- Simultaneous requests, ROUND_ROBIN = 1, all Req held continuously across 6 transactions → grants rotate SOF, PKT, DRCT, SOF, PKT, DRCT.
- Rogue strobe: during GNT_SOF, pktTxWEn = 1 with Data 8'hAA → SIETxData unchanged from SOF, arbProtErr = 1 for exactly one cycle.
- rst asserted mid-GNT_PKT → pktTxGnt = 0 and SIETxWEn = 0 on the next edge. After reset, a pending sofTxReq is granted 1 cycle after rst is released.
